// File: rtl/flipping_pkg.sv
// Shared types and helpers for the activation flipping sequencer.
package flipping_pkg;

  typedef enum logic [1:0] {
    BYPASS   = 2'd0,
    INVERT   = 2'd1,
    MAJORITY = 2'd2,
    RSVD     = 2'd3
  } flip_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } ctrl_state_e;

  localparam int FLIP_LAT = 2;
  localparam int POP_W    = 64;

  // Callers zero-extend narrower vectors to POP_W.
  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_W; i++) c += 32'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/flipping_out_fifo.sv
// Result buffer for the flipping sequencer: DEPTH-entry tile FIFO with
// wrap-around pointers; head entry is visible combinationally.
module flipping_out_fifo #(
  parameter int N     = 16,
  parameter int M     = 16,
  parameter int DEPTH = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       wr_i,
  input  logic [M-1:0][N-1:0]        wdata_i,
  input  logic                       rd_i,
  output logic [M-1:0][N-1:0]        rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [M-1:0][N-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [CW-1:0]       cnt_q;
  logic                wr_en, rd_en;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rd_en   = rd_i && !empty_o;
  // A pop in the same cycle frees the slot a write into a full buffer needs.
  assign wr_en   = wr_i && (!full_o || rd_en);
  assign rdata_o = mem_q[rptr_q];

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) wptr_q <= wrap_inc(wptr_q);
      if (rd_en) rptr_q <= wrap_inc(rptr_q);
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/flipping_seq_ctrl.sv
// Job sequencer for the 2-stage activation flipping datapath: picks per-lane
// f bits, tracks in-flight tiles and buffers results behind a credit scheme.
module flipping_seq_ctrl
  import flipping_pkg::*;
#(
  parameter int N     = 16,
  parameter int M     = 16,
  parameter int LAT   = FLIP_LAT,
  parameter int DEPTH = 3,
  parameter int TW    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [TW-1:0]       num_tiles_i,
  input  logic [1:0]          mode_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [M-1:0][N-1:0] in_act_i,
  output logic [M-1:0][N-1:0] dp_act_o,
  output logic [M-1:0]        dp_f_o,
  input  logic [M-1:0][N-1:0] dp_b_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [M-1:0][N-1:0] out_b_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [15:0]         flips_o
);
  localparam int CW = $clog2(DEPTH+1);

  ctrl_state_e         state_q, state_d;
  flip_mode_e          mode_q;
  logic [TW-1:0]       num_q, issued_q, popped_q;
  logic [CW-1:0]       credits_q, credits_d;
  logic [LAT-1:0]      vpipe_q;
  logic [15:0]         flips_q;
  logic [31:0]         fsum;
  logic [M-1:0]        lane_f;
  logic                issue, pop, flush, start_go;
  logic [M-1:0][N-1:0] fifo_rdata;
  logic                fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_cnt;

  for (genvar l = 0; l < M; l++) begin : g_lane
    assign lane_f[l] = (mode_q == INVERT) ||
                       ((mode_q == MAJORITY) &&
                        (popcount(POP_W'(in_act_i[l])) > 32'(N/2)));
  end

  assign flush    = abort_i && (state_q != IDLE);
  assign start_go = (state_q == IDLE) && start_i;
  assign pop      = out_valid_o && out_ready_i;
  // A pop this cycle returns a credit, so it can be spent on an issue in the
  // same cycle; otherwise the credit loop would cap throughput below 1/cycle.
  assign in_ready_o = (state_q == RUN) && !abort_i && (issued_q < num_q) &&
                      ((credits_q != '0) || pop);
  assign issue    = in_valid_i && in_ready_o;

  assign dp_act_o = issue ? in_act_i : '0;
  assign dp_f_o   = issue ? lane_f : '0;

  assign fsum = 32'(flips_q) + popcount(POP_W'(dp_f_o));

  always_comb begin
    credits_d = credits_q;
    case ({issue, pop})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    done_o  = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (start_i) state_d = (num_tiles_i == '0) ? FIN : RUN;
        RUN:   if (issued_q == num_q) state_d = DRAIN;
        DRAIN: if (popped_q == num_q) state_d = FIN;
        FIN: begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q    <= BYPASS;
      num_q     <= '0;
      issued_q  <= '0;
      popped_q  <= '0;
      credits_q <= CW'(DEPTH);
      vpipe_q   <= '0;
      flips_q   <= '0;
    end else if (flush) begin
      issued_q  <= '0;
      popped_q  <= '0;
      credits_q <= CW'(DEPTH);
      vpipe_q   <= '0;
    end else begin
      vpipe_q   <= LAT'({vpipe_q, issue});
      credits_q <= credits_d;
      if (start_go) begin
        mode_q   <= flip_mode_e'(mode_i);
        num_q    <= num_tiles_i;
        issued_q <= '0;
        popped_q <= '0;
        flips_q  <= '0;
      end
      if (issue) begin
        issued_q <= issued_q + TW'(1);
        flips_q  <= (fsum > 32'hFFFF) ? 16'hFFFF : fsum[15:0];
      end
      if (pop) popped_q <= popped_q + TW'(1);
    end
  end

  flipping_out_fifo #(.N(N), .M(M), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (flush),
    .wr_i    (vpipe_q[LAT-1]),
    .wdata_i (dp_b_i),
    .rd_i    (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign out_valid_o = !fifo_empty;
  assign out_b_o     = fifo_empty ? '0 : fifo_rdata;
  assign busy_o      = (state_q != IDLE);
  assign flips_o     = flips_q;

  // Every credit is either free, riding the datapath, or parked in the buffer.
  a_credit_conserve: assert property (@(posedge clk_i) disable iff (!rst_ni)
    32'(fifo_cnt) + popcount(POP_W'(vpipe_q)) + 32'(credits_q) == 32'(DEPTH));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fifo_full && vpipe_q[LAT-1] && !pop));

endmodule

// File: tb/tb_flipping_seq_ctrl.sv
// Bench for flipping_seq_ctrl: table of jobs plus hand-written abort/reset
// sequences, with a queue scoreboard fed at issue and drained at pop.
module tb_flipping_seq_ctrl;
  localparam int N = 16, M = 16, LAT = 2, DEPTH = 3, TW = 16;
  localparam int W = M * N;

  typedef logic [M-1:0][N-1:0] tile_t;
  typedef struct {
    logic [1:0]    mode;
    logic [TW-1:0] num;
    logic [N-1:0]  pa, pb;
    logic [N-1:0]  ea, eb;
    logic [15:0]   flips;
  } vec_t;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [TW-1:0] num_tiles = '0;
  logic [1:0]    mode = '0;
  tile_t         in_act = '0;
  tile_t         dp_act, dp_b, out_b;
  logic [M-1:0]  dp_f;
  logic          in_ready, out_valid, busy, done;
  logic [15:0]   flips;

  tile_t         dpa_q = '0, dpb_q = '0;
  logic [M-1:0]  dpf_q = '0;

  int    checks = 0, errors = 0;
  tile_t q[$];

  flipping_seq_ctrl #(.N(N), .M(M), .LAT(LAT), .DEPTH(DEPTH), .TW(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .num_tiles_i(num_tiles), .mode_i(mode),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_act_i(in_act),
    .dp_act_o(dp_act), .dp_f_o(dp_f), .dp_b_i(dp_b),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_b_o(out_b),
    .busy_o(busy), .done_o(done), .flips_o(flips)
  );

  always #5 clk = ~clk;

  // Two-register flipping datapath: input regs, lane-wise conditional invert, output regs.
  always @(posedge clk) begin
    dpa_q <= dp_act;
    dpf_q <= dp_f;
    for (int l = 0; l < M; l++) dpb_q[l] <= dpa_q[l] ^ {N{dpf_q[l]}};
  end
  assign dp_b = dpb_q;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [M-1:0] fmask(input tile_t t, input logic [1:0] m);
    logic [M-1:0] f;
    for (int l = 0; l < M; l++) begin
      case (m)
        2'd1:    f[l] = 1'b1;
        2'd2:    f[l] = ($countones(t[l]) > N/2);
        default: f[l] = 1'b0;
      endcase
    end
    return f;
  endfunction

  function automatic tile_t model(input tile_t t, input logic [1:0] m);
    tile_t        r;
    logic [M-1:0] f;
    f = fmask(t, m);
    for (int l = 0; l < M; l++) r[l] = f[l] ? ~t[l] : t[l];
    return r;
  endfunction

  function automatic tile_t mk(input logic [N-1:0] pa, input logic [N-1:0] pb);
    tile_t r;
    for (int l = 0; l < M; l++) r[l] = (l % 2 == 1) ? pb : pa;
    return r;
  endfunction

  function automatic tile_t mk_seq(input int k);
    tile_t r;
    for (int l = 0; l < M; l++) r[l] = N'(k * 16 + l + 1);
    return r;
  endfunction

  task automatic run_job(input string nm, input logic [1:0] m, input logic [TW-1:0] n,
                         input tile_t tin, input tile_t texp, input bit seq,
                         input int stall, input logic [15:0] exp_flips);
    int    k = 0, pops = 0, busy_cnt = 0, done_cnt = 0, ov_cnt = 0, st_iss = 0;
    int    first_iss = -1, first_ov = -1, last_pop = -1;
    int    budget;
    bit    fin = 1'b0;
    tile_t t, e;
    budget = 2 * int'(n) + stall + 40;
    q.delete();
    @(negedge clk);
    mode = m; num_tiles = n; start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      t         = seq ? mk_seq(k) : tin;
      in_valid  = (k < int'(n));
      in_act    = in_valid ? t : '0;
      out_ready = (cyc >= stall);
      #1;
      if (busy) busy_cnt++;
      if (in_valid && in_ready) begin
        chk({nm, " dp_act"}, W'(dp_act), W'(t));
        chk({nm, " dp_f"}, W'(dp_f), W'(fmask(t, m)));
        q.push_back(seq ? model(t, m) : texp);
        if (first_iss < 0) first_iss = cyc;
        if (cyc < stall) st_iss++;
        k++;
      end
      if (out_valid) begin
        ov_cnt++;
        if (first_ov < 0) first_ov = cyc;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s extra_out: got %0h expected no output", nm, out_b);
        end else begin
          e = q.pop_front();
          chk({nm, " out_b"}, W'(out_b), W'(e));
        end
        pops++;
        last_pop = cyc;
      end
      if (done) begin
        done_cnt++;
        fin = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk({nm, " finished"}, W'(fin), W'(1'b1));
    chk({nm, " done_cnt"}, W'(done_cnt), W'(1));
    chk({nm, " pops"}, W'(pops), W'(int'(n)));
    chk({nm, " sb_left"}, W'(q.size()), W'(0));
    chk({nm, " flips"}, W'(flips), W'(exp_flips));
    chk({nm, " idle_busy"}, W'(busy), W'(1'b0));
    chk({nm, " idle_done"}, W'(done), W'(1'b0));
    if (n == '0) begin
      chk({nm, " busy_cycles"}, W'(busy_cnt), W'(1));
      chk({nm, " no_out"}, W'(ov_cnt), W'(0));
    end else if (stall == 0) begin
      chk({nm, " first_lat"}, W'(first_ov - first_iss), W'(LAT + 1));
      chk({nm, " throughput"}, W'(last_pop - first_ov), W'(int'(n) - 1));
    end else begin
      chk({nm, " stalled_iss"}, W'(st_iss), W'((int'(n) < DEPTH) ? int'(n) : DEPTH));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int   iss;
    tbl[0] = '{2'd0, 16'd4,    16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'd0};
    tbl[1] = '{2'd2, 16'd4,    16'hFFF0, 16'h00FF, 16'h000F, 16'h00FF, 16'd32};
    tbl[2] = '{2'd1, 16'd3,    16'h1234, 16'hABCD, 16'hEDCB, 16'h5432, 16'd48};
    tbl[3] = '{2'd3, 16'd2,    16'hA5A5, 16'h5A5A, 16'hA5A5, 16'h5A5A, 16'd0};
    tbl[4] = '{2'd2, 16'd2,    16'h01FF, 16'h0F0F, 16'hFE00, 16'h0F0F, 16'd16};
    tbl[5] = '{2'd2, 16'd1,    16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'd8};
    tbl[6] = '{2'd1, 16'd4100, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF};

    #1;
    chk("rst in_ready", W'(in_ready), W'(1'b0));
    chk("rst out_valid", W'(out_valid), W'(1'b0));
    chk("rst busy", W'(busy), W'(1'b0));
    chk("rst done", W'(done), W'(1'b0));
    chk("rst flips", W'(flips), W'(16'd0));
    chk("rst dp_act", W'(dp_act), W'(0));
    chk("rst dp_f", W'(dp_f), W'(0));
    chk("rst out_b", W'(out_b), W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_job($sformatf("vec%0d", i), tbl[i].mode, tbl[i].num, mk(tbl[i].pa, tbl[i].pb),
              mk(tbl[i].ea, tbl[i].eb), 1'b0, 0, tbl[i].flips);

    run_job("zero", 2'd0, 16'd0, '0, '0, 1'b0, 0, 16'd0);
    run_job("backpressure", 2'd1, 16'd6, '0, '0, 1'b1, 10, 16'd96);

    // Abort with tile 0 buffered and tiles 1,2 inside the datapath.
    q.delete();
    iss = 0;
    @(negedge clk);
    mode = 2'd0; num_tiles = 16'd8; start = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_act   = mk_seq(c);
      abort    = (c == 3);
      #1;
      if (in_valid && in_ready) iss++;
      if (abort) begin
        chk("abort buffered", W'(out_valid), W'(1'b1));
        chk("abort issued", W'(iss), W'(3));
        chk("abort no_done", W'(done), W'(1'b0));
      end
      @(negedge clk);
    end
    abort = 1'b0; in_valid = 1'b0;
    #1;
    chk("abort busy", W'(busy), W'(1'b0));
    chk("abort out_valid", W'(out_valid), W'(1'b0));
    chk("abort in_ready", W'(in_ready), W'(1'b0));
    repeat (3) begin
      @(negedge clk); #1;
      chk("abort stale_out", W'(out_valid), W'(1'b0));
      chk("abort stale_done", W'(done), W'(1'b0));
    end
    run_job("post_abort", 2'd0, 16'd6, '0, '0, 1'b1, 10, 16'd0);

    // Asynchronous reset landing between clock edges in the middle of a job.
    @(negedge clk);
    mode = 2'd1; num_tiles = 16'd8; start = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      in_valid = 1'b1;
      in_act   = mk_seq(7);
      @(negedge clk);
    end
    #1;
    chk("prerst flips", W'(flips), W'(16'd64));
    chk("prerst out_valid", W'(out_valid), W'(1'b1));
    #1 rst_n = 1'b0;
    #1;
    chk("async in_ready", W'(in_ready), W'(1'b0));
    chk("async out_valid", W'(out_valid), W'(1'b0));
    chk("async out_b", W'(out_b), W'(0));
    chk("async busy", W'(busy), W'(1'b0));
    chk("async done", W'(done), W'(1'b0));
    chk("async flips", W'(flips), W'(16'd0));
    chk("async dp_act", W'(dp_act), W'(0));
    chk("async dp_f", W'(dp_f), W'(0));
    start = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst start_ignored", W'(busy), W'(1'b0));
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_job("post_rst", 2'd1, 16'd5, '0, '0, 1'b1, 0, 16'd80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
